alu_scheduler: RTL and testbench
================================

# alu_scheduler

Sequencer and arbiter for the single shared ALU in the TinyCPU datapath. Sits between the ALU and its two requesters, the PC-update stage (PC + increment) and the execute stage (register operands plus op code). Grants the ALU to one requester at a time and drives the ALU operand/op inputs. Implements `ALU_OP_MUL`, which the combinational ALU lacks, as a fixed-length shift-add sequence over `ALU_OP_ADD`.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `PC_INCR`, 1, constant added to the PC on a PC request
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `pc_req_valid`  in  1  PC-update request
- `pc_req_ready`  out  1  PC request accepted this cycle
- `pc_value`  in  DATA_WIDTH  current PC
- `pc_resp_valid`  out  1  `resp_data` holds PC + PC_INCR
- `pc_resp_ready`  in  1  PC requester consumes response
- `exec_req_valid`  in  1  execute request
- `exec_req_ready`  out  1  execute request accepted this cycle
- `exec_op`  in  5  ALU op code from arch_defines
- `exec_a`, `exec_b`  in  DATA_WIDTH  operands
- `exec_resp_valid`  out  1  `resp_data` holds execute result
- `exec_resp_ready`  in  1  execute requester consumes response
- `resp_data`  out  DATA_WIDTH  registered result, shared by both response ports
- `busy`  out  1  high in any state other than IDLE
- `alu_in0`, `alu_in1`  out  DATA_WIDTH  ALU operands
- `alu_op_select`  out  5  ALU op
- `alu_out`  in  DATA_WIDTH  combinational ALU result

## Operation
- States: IDLE, OP, MUL, RESP.
- **IDLE:** `busy`=0. ALU is driven with 0, 0, `ALU_OP_ADD`.
  - If exactly one `*_req_valid` is high, that requester is granted.
  - If both are high, round-robin applies. The requester not granted last wins. After reset, PC wins first.
  - `*_req_ready` is high only in IDLE, only for the granted requester, and only in the grant cycle.
- **On grant:** register the operands, the op, and the owner.
  - PC request: op=ADD, a=`pc_value`, b=`PC_INCR`.
  - Execute request, `exec_op`≠MUL: go to OP.
  - Execute request, `exec_op`=MUL: go to MUL with acc=0, mcand=a, mplier=b, count=0.
- **OP (1 cycle):** drive the ALU with the registered a, b, op. Capture `alu_out` into `resp_data`, then go to RESP.
- **MUL (DATA_WIDTH cycles):** each cycle:
  - drive `alu_in0`=acc, `alu_in1`= mplier[0] ? mcand : 0, op=`ALU_OP_ADD`;
  - acc←`alu_out`, mcand←mcand<<1, mplier←mplier>>1, count++.
  - When count = DATA_WIDTH-1, load the final `alu_out` into `resp_data` and go to RESP.
  - There is no early termination.
  - The result is the low DATA_WIDTH bits of the product, unsigned (equal to the signed low half). Overflow bits are discarded.
- **RESP:** the owner's `*_resp_valid`=1 and `resp_data` is stable. Other ALU-facing outputs match IDLE.
  - Leave RESP on the edge where the owner's `*_resp_ready`=1.
  - No new grant is made in that cycle. The next grant is possible in IDLE one cycle later.
- Requesters must hold `valid` and payload stable until `ready`. A request arriving during busy waits.
- Unknown op codes pass straight through to the ALU via the OP state.
- **`rst`** (at any point, including mid-MUL or in RESP):
  - next state IDLE, abandoning any operation without a response;
  - all `*_ready`/`*_resp_valid`=0, `busy`=0, `resp_data`=0, ALU outputs=0/0/ADD;
  - round-robin pointer favours PC.

## Timing
- Request accepted at edge t (ready high in cycle t−1..t).
  - Single-cycle op: result latched at edge t+1, `resp_valid` visible in cycle t+1.
  - MUL: DATA_WIDTH step cycles; `resp_valid` visible DATA_WIDTH cycles after acceptance (32 by default).
- Minimum spacing between successive grants is 3 cycles for non-MUL ops: accept, OP, RESP with immediate ready, then IDLE.
- `alu_in*`/`alu_op_select` are combinational from registered state only; there is no path from `*_req_*` to the ALU.
- Arithmetic is DATA_WIDTH-wide with wrap-around (PC 0xFFFFFFFF + 1 → 0).

## Structure
- Op codes (`ALU_OP_ADD`, `ALU_OP_MUL`, …) and state encodings (2-bit) belong in arch_defines.v.
- One sub-module is natural: `shift_add_mul_seq`. It holds acc/mcand/mplier/count, produces the ALU operands for the MUL state, and raises a `last` flag.
- Arbitration, FSM, and response logic stay in `alu_scheduler`.

## Test plan
- **PC request alone:** `pc_value`=0x00000010 → `pc_resp_valid` in cycle t+1 with `resp_data`=0x00000011; `pc_value`=0xFFFFFFFF → 0x00000000.
- **Simultaneous requests:** both valid from reset, exec ADD 3+4, both holding valid → PC granted first; after its response, exec granted and returns 7. Next simultaneous pair: exec loses to PC only if exec was last granted.
- **MUL:**
  - 7×6 → `resp_data`=42, `exec_resp_valid` exactly 32 cycles after acceptance;
  - 0xFFFFFFFF×0xFFFFFFFF → 0x00000001;
  - 0×0x12345678 → 0.
- **Response backpressure:** hold `exec_resp_ready`=0 for 10 cycles with a pending PC request → `resp_data` stable, `pc_req_ready` stays 0, PC granted only after exec response is consumed.
- **Reset mid-MUL (step 15):** all outputs return to reset values next cycle, no response issued; next PC request is granted normally.

Source files
------------

// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: ALU op codes, FSM state and owner encodings.
package alu_scheduler_pkg;

  localparam logic [4:0] ALU_OP_ADD = 5'd0;
  localparam logic [4:0] ALU_OP_SUB = 5'd1;
  localparam logic [4:0] ALU_OP_AND = 5'd2;
  localparam logic [4:0] ALU_OP_OR  = 5'd3;
  localparam logic [4:0] ALU_OP_XOR = 5'd4;
  localparam logic [4:0] ALU_OP_SLL = 5'd5;
  localparam logic [4:0] ALU_OP_SRL = 5'd6;
  localparam logic [4:0] ALU_OP_MUL = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } sched_state_e;

  typedef enum logic {
    OWN_PC   = 1'b0,
    OWN_EXEC = 1'b1
  } owner_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op == ALU_OP_MUL;
  endfunction

endpackage

// File: rtl/alu_scheduler_mul_seq.sv
// Shift-add multiply sequencer: one ALU add per step, DATA_WIDTH steps, low half of product.
module alu_scheduler_mul_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_alu_out,
  output logic [DATA_WIDTH-1:0] o_alu_in0,
  output logic [DATA_WIDTH-1:0] o_alu_in1,
  output logic                  o_last
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [CW-1:0]         r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= i_alu_out;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

  // Partial product is selected here so the ALU only ever sees an add.
  assign o_alu_in0 = r_acc;
  assign o_alu_in1 = r_mplier[0] ? r_mcand : '0;
  assign o_last    = (r_count == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/alu_scheduler.sv
// Arbiter and sequencer for the shared ALU: round-robin between PC-update and execute,
// single-cycle ops via OP, multiply via repeated adds in MUL, held response in RESP.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned PC_INCR    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pc_req_valid,
  output logic                  o_pc_req_ready,
  input  logic [DATA_WIDTH-1:0] i_pc_value,
  output logic                  o_pc_resp_valid,
  input  logic                  i_pc_resp_ready,
  input  logic                  i_exec_req_valid,
  output logic                  o_exec_req_ready,
  input  logic [4:0]            i_exec_op,
  input  logic [DATA_WIDTH-1:0] i_exec_a,
  input  logic [DATA_WIDTH-1:0] i_exec_b,
  output logic                  o_exec_resp_valid,
  input  logic                  i_exec_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_alu_in0,
  output logic [DATA_WIDTH-1:0] o_alu_in1,
  output logic [4:0]            o_alu_op_select,
  input  logic [DATA_WIDTH-1:0] i_alu_out
);

  sched_state_e          r_state;
  owner_e                r_owner;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [4:0]            r_op;
  logic                  r_prefer_pc;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_pc_resp_valid;
  logic                  r_exec_resp_valid;
  logic                  r_busy;

  logic                  w_idle;
  logic                  w_grant_pc;
  logic                  w_grant_exec;
  logic                  w_exec_is_mul;
  logic                  w_owner_ready;
  logic [DATA_WIDTH-1:0] w_mul_in0;
  logic [DATA_WIDTH-1:0] w_mul_in1;
  logic                  w_mul_last;

  // Reset masks the grant so no ready can escape while rst is held.
  assign w_idle        = (r_state == ST_IDLE) && !i_rst;
  assign w_grant_pc    = w_idle && i_pc_req_valid && (!i_exec_req_valid || r_prefer_pc);
  assign w_grant_exec  = w_idle && i_exec_req_valid && (!i_pc_req_valid || !r_prefer_pc);
  assign w_exec_is_mul = is_mul_op(i_exec_op);
  assign w_owner_ready = (r_owner == OWN_PC) ? i_pc_resp_ready : i_exec_resp_ready;

  alu_scheduler_mul_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul_seq (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_grant_exec && w_exec_is_mul),
    .i_step    (r_state == ST_MUL),
    .i_a       (i_exec_a),
    .i_b       (i_exec_b),
    .i_alu_out (i_alu_out),
    .o_alu_in0 (w_mul_in0),
    .o_alu_in1 (w_mul_in1),
    .o_last    (w_mul_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= ST_IDLE;
      r_owner           <= OWN_PC;
      r_a               <= '0;
      r_b               <= '0;
      r_op              <= ALU_OP_ADD;
      r_prefer_pc       <= 1'b1;
      r_resp_data       <= '0;
      r_pc_resp_valid   <= 1'b0;
      r_exec_resp_valid <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_pc) begin
            r_owner     <= OWN_PC;
            r_a         <= i_pc_value;
            r_b         <= DATA_WIDTH'(PC_INCR);
            r_op        <= ALU_OP_ADD;
            r_prefer_pc <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_OP;
          end else if (w_grant_exec) begin
            r_owner     <= OWN_EXEC;
            r_a         <= i_exec_a;
            r_b         <= i_exec_b;
            r_op        <= i_exec_op;
            r_prefer_pc <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= w_exec_is_mul ? ST_MUL : ST_OP;
          end
        end
        ST_OP: begin
          r_resp_data <= i_alu_out;
          if (r_owner == OWN_PC) r_pc_resp_valid <= 1'b1;
          else                   r_exec_resp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_MUL: begin
          if (w_mul_last) begin
            r_resp_data       <= i_alu_out;
            r_exec_resp_valid <= 1'b1;
            r_state           <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_owner_ready) begin
            r_pc_resp_valid   <= 1'b0;
            r_exec_resp_valid <= 1'b0;
            r_busy            <= 1'b0;
            r_state           <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ALU inputs depend only on registered state, never on the request ports.
  always_comb begin
    o_alu_in0       = '0;
    o_alu_in1       = '0;
    o_alu_op_select = ALU_OP_ADD;
    case (r_state)
      ST_OP: begin
        o_alu_in0       = r_a;
        o_alu_in1       = r_b;
        o_alu_op_select = r_op;
      end
      ST_MUL: begin
        o_alu_in0       = w_mul_in0;
        o_alu_in1       = w_mul_in1;
        o_alu_op_select = ALU_OP_ADD;
      end
      default: ;
    endcase
  end

  assign o_pc_req_ready    = w_grant_pc;
  assign o_exec_req_ready  = w_grant_exec;
  assign o_pc_resp_valid   = r_pc_resp_valid;
  assign o_exec_resp_valid = r_exec_resp_valid;
  assign o_resp_data       = r_resp_data;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural ALU, transaction-level reference model, random traffic.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pc_req_valid = 1'b0;
  logic         pc_req_ready;
  logic [W-1:0] pc_value = '0;
  logic         pc_resp_valid;
  logic         pc_resp_ready = 1'b0;
  logic         exec_req_valid = 1'b0;
  logic         exec_req_ready;
  logic [4:0]   exec_op = '0;
  logic [W-1:0] exec_a = '0;
  logic [W-1:0] exec_b = '0;
  logic         exec_resp_valid;
  logic         exec_resp_ready = 1'b0;
  logic [W-1:0] resp_data;
  logic         busy;
  logic [W-1:0] alu_in0;
  logic [W-1:0] alu_in1;
  logic [4:0]   alu_op_select;
  logic [W-1:0] alu_out;

  int total = 0;
  int bad   = 0;
  bit prefer_pc = 1'b1;
  bit gq[$];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [4:0] op, input logic [W-1:0] a, b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      ALU_OP_SLL: return a << b[4:0];
      ALU_OP_SRL: return a >> b[4:0];
      default:    return a ^ (b + 32'h5a5a_0001);
    endcase
  endfunction

  function automatic logic [W-1:0] ref_result(input bit is_pc, input logic [4:0] op,
                                              input logic [W-1:0] a, b);
    logic [W-1:0] p;
    if (is_pc) return a + 32'd1;
    if (op == ALU_OP_MUL) begin
      p = a * b;
      return p;
    end
    return alu_f(op, a, b);
  endfunction

  always_comb alu_out = alu_f(alu_op_select, alu_in0, alu_in1);

  alu_scheduler #(.DATA_WIDTH(W), .PC_INCR(1)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_pc_req_valid    (pc_req_valid),
    .o_pc_req_ready    (pc_req_ready),
    .i_pc_value        (pc_value),
    .o_pc_resp_valid   (pc_resp_valid),
    .i_pc_resp_ready   (pc_resp_ready),
    .i_exec_req_valid  (exec_req_valid),
    .o_exec_req_ready  (exec_req_ready),
    .i_exec_op         (exec_op),
    .i_exec_a          (exec_a),
    .i_exec_b          (exec_b),
    .o_exec_resp_valid (exec_resp_valid),
    .i_exec_resp_ready (exec_resp_ready),
    .o_resp_data       (resp_data),
    .o_busy            (busy),
    .o_alu_in0         (alu_in0),
    .o_alu_in1         (alu_in1),
    .o_alu_op_select   (alu_op_select),
    .i_alu_out         (alu_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pc_rv"}, pc_resp_valid, 0);
    chk({tag, "_ex_rv"}, exec_resp_valid, 0);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_in0"}, alu_in0, 0);
    chk({tag, "_in1"}, alu_in1, 0);
    chk({tag, "_op"}, alu_op_select, ALU_OP_ADD);
  endtask

  // One complete request/response from one requester; hold = cycles of response backpressure.
  task automatic run_req(input bit is_pc, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
    int n;
    int lat;
    logic [W-1:0] expv;
    logic [W-1:0] held;
    expv = ref_result(is_pc, op, a, b);
    @(negedge clk);
    if (is_pc) begin
      pc_req_valid = 1'b1; pc_value = a;
    end else begin
      exec_req_valid = 1'b1; exec_op = op; exec_a = a; exec_b = b;
    end
    n = 0;
    #1;
    while (!(is_pc ? pc_req_ready : exec_req_ready) && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk("granted", is_pc ? pc_req_ready : exec_req_ready, 1);
    if (!(is_pc ? pc_req_ready : exec_req_ready)) begin
      if (is_pc) pc_req_valid = 1'b0; else exec_req_valid = 1'b0;
      return;
    end
    gq.push_back(is_pc);
    prefer_pc = !is_pc;
    @(posedge clk);
    @(negedge clk);
    if (is_pc) pc_req_valid = 1'b0; else exec_req_valid = 1'b0;
    chk("busy_after_grant", busy, 1);
    lat = 0;
    while (!(is_pc ? pc_resp_valid : exec_resp_valid) && lat < 100) begin
      @(negedge clk); lat++;
    end
    chk(is_pc ? "pc_latency" : "exec_latency", lat,
        (!is_pc && op == ALU_OP_MUL) ? W : 1);
    chk(is_pc ? "pc_data" : "exec_data", resp_data, expv);
    chk("other_resp_valid", is_pc ? exec_resp_valid : pc_resp_valid, 0);
    held = resp_data;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", resp_data, held);
      chk("hold_valid", is_pc ? pc_resp_valid : exec_resp_valid, 1);
      chk("hold_other_ready", is_pc ? exec_req_ready : pc_req_ready, 0);
    end
    if (is_pc) pc_resp_ready = 1'b1; else exec_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (is_pc) pc_resp_ready = 1'b0; else exec_resp_ready = 1'b0;
    chk("resp_drop", is_pc ? pc_resp_valid : exec_resp_valid, 0);
  endtask

  task automatic run_pair(input logic [W-1:0] pa, input logic [4:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    bit exp_first;
    exp_first = prefer_pc;
    gq.delete();
    fork
      run_req(1'b1, ALU_OP_ADD, pa, '0, hold);
      run_req(1'b0, op, a, b, hold);
    join
    if (gq.size() == 2) chk("rr_first", gq[0], exp_first);
    else chk("rr_grant_count", gq.size(), 2);
  endtask

  logic [4:0] ops[10] = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
                          ALU_OP_SLL, ALU_OP_SRL, ALU_OP_MUL, 5'd19, 5'd31};

  initial begin
    int seen;
    // Reset state, with both requesters asserting valid during reset
    rst = 1'b1;
    pc_req_valid = 1'b1;
    exec_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_idle_outputs("reset");
    chk("reset_pc_ready", pc_req_ready, 0);
    chk("reset_exec_ready", exec_req_ready, 0);
    pc_req_valid = 1'b0;
    exec_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous from reset: PC first, exec 3+4 afterwards
    run_pair(32'h0000_0010, ALU_OP_ADD, 32'd3, 32'd4, 0);
    run_req(1'b1, ALU_OP_ADD, 32'hFFFF_FFFF, '0, 0);
    run_pair(32'h1000_0000, ALU_OP_SUB, 32'd10, 32'd3, 1);
    run_req(1'b0, ALU_OP_XOR, 32'h0F0F_0F0F, 32'hFFFF_0000, 0);
    run_pair(32'h2000_0000, ALU_OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);

    // Multiply corners
    run_req(1'b0, ALU_OP_MUL, 32'd7, 32'd6, 0);
    run_req(1'b0, ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_req(1'b0, ALU_OP_MUL, 32'd0, 32'h1234_5678, 0);
    run_req(1'b0, 5'd25, 32'h1111_2222, 32'h0000_0003, 0);

    // Exec response held 10 cycles while a PC request waits
    gq.delete();
    fork
      run_req(1'b0, ALU_OP_OR, 32'hA000_0005, 32'h0000_0F00, 10);
      begin
        @(negedge clk); @(negedge clk);
        run_req(1'b1, ALU_OP_ADD, 32'h0000_4000, '0, 0);
      end
    join
    if (gq.size() == 2) chk("bp_order", gq[0], 0);
    else chk("bp_grant_count", gq.size(), 2);

    // Reset during a multiply
    @(negedge clk);
    exec_req_valid = 1'b1; exec_op = ALU_OP_MUL; exec_a = 32'd5; exec_b = 32'd9;
    #1;
    chk("mid_grant", exec_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    exec_req_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    prefer_pc = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (exec_resp_valid || pc_resp_valid || busy) seen++;
    end
    chk("no_resp_after_rst", seen, 0);
    run_pair(32'h0000_0100, ALU_OP_ADD, 32'd1, 32'd2, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      int mode;
      logic [4:0] op;
      logic [W-1:0] a, b, p;
      mode = $urandom_range(0, 2);
      op = ops[$urandom_range(0, 9)];
      a = $urandom; b = $urandom; p = $urandom;
      case (mode)
        0: run_req(1'b1, ALU_OP_ADD, p, '0, $urandom_range(0, 3));
        1: run_req(1'b0, op, a, b, $urandom_range(0, 3));
        default: run_pair(p, op, a, b, $urandom_range(0, 3));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
